// File: rtl/usb_uart_rx_bridge.sv
// 8N1 UART receiver feeding a small byte FIFO that presents a valid/ready stream
// to the USB serial core's uart_in pipeline.
module usb_uart_rx_bridge #(
  parameter int CLK_HZ     = 48000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic          rxMeta_q, rxSync_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frameErr_q, overrun_q;
  logic          stopGood, stopBad;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wrPtr_q, rdPtr_q;
  logic          full, empty, push, pop;

  // Idle-high synchronizer so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    stopGood = 1'b0;
    stopBad  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxSync_q) begin
          cnt_d   = HALF_M1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rxSync_q) begin
            cnt_d    = DIV_M1;
            bitIdx_d = '0;
            state_d  = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxSync_q, shift_q[7:1]};
          cnt_d   = DIV_M1;
          if (bitIdx_q == 3'd7) state_d = S_STOP;
          else                  bitIdx_d = bitIdx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rxSync_q) begin
            stopGood = 1'b1;
            state_d  = S_IDLE;
          end else begin
            stopBad = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BREAK: begin
        if (rxSync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fullness is taken before any same-cycle pop, so a pop cannot rescue the byte.
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign push  = stopGood && !full;
  assign pop   = !empty && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      frameErr_q <= stopBad;
      overrun_q  <= stopGood && full;
      if (push) begin
        mem_q[wrPtr_q[AW-1:0]] <= shift_q;
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  assign out_data  = mem_q[rdPtr_q[AW-1:0]];
  assign out_valid = !empty;
  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;

endmodule
